// File: rtl/note_player_if.sv
// Note handshake between song reader, note player, frequency ROM and sample generator.
// master = song reader / ROM / downstream side; slave = the note player.
interface note_player_if #(
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6,
  parameter int STEP_WIDTH = 20
);
  logic                  play;
  logic                  new_note;
  logic [NOTE_WIDTH-1:0] note;
  logic [DUR_WIDTH-1:0]  duration;
  logic                  beat;
  logic [NOTE_WIDTH-1:0] freq_addr;
  logic [STEP_WIDTH-1:0] freq_data;
  logic [STEP_WIDTH-1:0] step_size;
  logic                  note_active;
  logic [DUR_WIDTH-1:0]  beats_left;
  logic                  note_done;

  modport master (
    output play, new_note, note, duration, beat, freq_data,
    input  freq_addr, step_size, note_active, beats_left, note_done
  );

  modport slave (
    input  play, new_note, note, duration, beat, freq_data,
    output freq_addr, step_size, note_active, beats_left, note_done
  );
endinterface

// File: rtl/note_player.sv
// Latches a note, fetches its phase step from the frequency ROM, holds it for the
// note's beat count and pulses note_done; new_note with play aborts and relatches.
module note_player #(
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6,
  parameter int STEP_WIDTH = 20
) (
  input  logic          clk,
  input  logic          reset,
  note_player_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

  state_t                state_q;
  logic [NOTE_WIDTH-1:0] note_q;
  logic [DUR_WIDTH-1:0]  beats_left_q;
  logic [STEP_WIDTH-1:0] step_q;
  logic                  start;

  assign start = bus.new_note && bus.play;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      note_q       <= '0;
      beats_left_q <= '0;
      step_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          step_q <= '0;
          if (start) begin
            note_q       <= bus.note;
            beats_left_q <= bus.duration;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          if (start) begin
            note_q       <= bus.note;
            beats_left_q <= bus.duration;
            state_q      <= FETCH;
          end else if (beats_left_q == '0) begin
            step_q  <= '0;
            state_q <= DONE;
          end else begin
            // Note 0 is a rest: silence regardless of what the ROM holds there.
            step_q  <= (note_q == '0) ? '0 : bus.freq_data;
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (start) begin
            note_q       <= bus.note;
            beats_left_q <= bus.duration;
            state_q      <= FETCH;
          end else if (bus.beat && bus.play) begin
            if (beats_left_q <= DUR_WIDTH'(1)) begin
              beats_left_q <= '0;
              step_q       <= '0;
              state_q      <= DONE;
            end else begin
              beats_left_q <= beats_left_q - DUR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            note_q       <= bus.note;
            beats_left_q <= bus.duration;
            state_q      <= FETCH;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.freq_addr   = note_q;
  assign bus.step_size   = step_q;
  assign bus.beats_left  = beats_left_q;
  assign bus.note_active = (state_q == FETCH) || (state_q == PLAY);
  assign bus.note_done   = (state_q == DONE);

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a combinational frequency ROM model.
module tb_note_player;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  note_player_if bus ();

  note_player dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [19:0] rom(input logic [5:0] a);
    if (a == 6'd12) return 20'h0A3D7;
    return 20'h01000 + 20'(a) * 20'h00111;
  endfunction

  assign bus.freq_data = rom(bus.freq_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_beat();
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
  endtask

  task automatic start_note(input logic [5:0] n, input logic [5:0] d);
    bus.note     = n;
    bus.duration = d;
    bus.new_note = 1'b1;
    tick();
    bus.new_note = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL rst_step got %h want 0", bus.step_size); end
    checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", bus.note_active); end
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.note_done); end
    checks++; if (bus.beats_left !== 6'd0) begin errors++; $display("FAIL rst_beats got %0d want 0", bus.beats_left); end
    reset = 1'b1;
    tick();
    // Get to PLAY with 5 beats left, then reset mid-note.
    start_note(6'd3, 6'd8);
    tick();
    pulse_beat(); pulse_beat(); pulse_beat();
    checks++; if (bus.beats_left !== 6'd5) begin errors++; $display("FAIL mid_beats got %0d want 5", bus.beats_left); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL midrst_step got %h want 0", bus.step_size); end
    checks++; if (bus.beats_left !== 6'd0) begin errors++; $display("FAIL midrst_beats got %0d want 0", bus.beats_left); end
    checks++; if (bus.freq_addr !== 6'd0) begin errors++; $display("FAIL midrst_addr got %0d want 0", bus.freq_addr); end
    checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b want 0", bus.note_active); end
    reset = 1'b1;
    tick();
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.note_done); end
  endtask

  task automatic test_ignore_paused();
    bus.play = 1'b0;
    start_note(6'd9, 6'd2);
    checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL paused_new_note active got %b want 0", bus.note_active); end
    bus.play = 1'b1;
  endtask

  task automatic test_basic();
    start_note(6'd12, 6'd3);
    checks++; if (bus.note_active !== 1'b1) begin errors++; $display("FAIL basic_fetch_active got %b want 1", bus.note_active); end
    checks++; if (bus.freq_addr !== 6'd12) begin errors++; $display("FAIL basic_addr got %0d want 12", bus.freq_addr); end
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL basic_fetch_step got %h want 0", bus.step_size); end
    tick();
    checks++; if (bus.step_size !== 20'h0A3D7) begin errors++; $display("FAIL basic_step got %h want 0a3d7", bus.step_size); end
    pulse_beat(); pulse_beat();
    checks++; if (bus.beats_left !== 6'd1) begin errors++; $display("FAIL basic_beats got %0d want 1", bus.beats_left); end
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", bus.note_done); end
    pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", bus.note_done); end
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL basic_done_step got %h want 0", bus.step_size); end
    checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL basic_done_active got %b want 0", bus.note_active); end
    tick();
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bus.note_done); end
  endtask

  task automatic test_rest_and_zero();
    start_note(6'd0, 6'd4);
    tick();
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL rest_step got %h want 0", bus.step_size); end
    checks++; if (bus.note_active !== 1'b1) begin errors++; $display("FAIL rest_active got %b want 1", bus.note_active); end
    pulse_beat(); pulse_beat(); pulse_beat();
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL rest_early_done got %b want 0", bus.note_done); end
    pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL rest_done got %b want 1", bus.note_done); end
    tick();
    start_note(6'd5, 6'd0);
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL zero_fetch_done got %b want 0", bus.note_done); end
    tick();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.note_done); end
    checks++; if (bus.step_size !== 20'h0) begin errors++; $display("FAIL zero_step got %h want 0", bus.step_size); end
    tick();
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", bus.note_done); end
  endtask

  task automatic test_pause();
    start_note(6'd9, 6'd4);
    tick();
    checks++; if (bus.step_size !== rom(6'd9)) begin errors++; $display("FAIL pause_step got %h want %h", bus.step_size, rom(6'd9)); end
    pulse_beat(); pulse_beat();
    bus.play = 1'b0;
    pulse_beat(); pulse_beat(); pulse_beat();
    checks++; if (bus.beats_left !== 6'd2) begin errors++; $display("FAIL pause_beats got %0d want 2", bus.beats_left); end
    checks++; if (bus.step_size !== rom(6'd9)) begin errors++; $display("FAIL pause_hold got %h want %h", bus.step_size, rom(6'd9)); end
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL pause_done got %b want 0", bus.note_done); end
    bus.play = 1'b1;
    pulse_beat();
    checks++; if (bus.beats_left !== 6'd1) begin errors++; $display("FAIL resume_beats got %0d want 1", bus.beats_left); end
    pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL resume_done got %b want 1", bus.note_done); end
    tick();
  endtask

  task automatic test_preempt();
    start_note(6'd3, 6'd5);
    tick();
    pulse_beat(); pulse_beat();
    checks++; if (bus.beats_left !== 6'd3) begin errors++; $display("FAIL pre_beats got %0d want 3", bus.beats_left); end
    start_note(6'd7, 6'd2);
    checks++; if (bus.freq_addr !== 6'd7) begin errors++; $display("FAIL pre_addr got %0d want 7", bus.freq_addr); end
    checks++; if (bus.beats_left !== 6'd2) begin errors++; $display("FAIL pre_relatch got %0d want 2", bus.beats_left); end
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL pre_no_done got %b want 0", bus.note_done); end
    tick();
    checks++; if (bus.step_size !== rom(6'd7)) begin errors++; $display("FAIL pre_step got %h want %h", bus.step_size, rom(6'd7)); end
    pulse_beat();
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL pre_early_done got %b want 0", bus.note_done); end
    pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL pre_done got %b want 1", bus.note_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    start_note(6'd4, 6'd1);
    tick();
    pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", bus.note_done); end
    start_note(6'd6, 6'd2);
    checks++; if (bus.note_done !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse got %b want 0", bus.note_done); end
    checks++; if (bus.note_active !== 1'b1) begin errors++; $display("FAIL b2b_fetch got %b want 1", bus.note_active); end
    checks++; if (bus.freq_addr !== 6'd6) begin errors++; $display("FAIL b2b_addr got %0d want 6", bus.freq_addr); end
    tick();
    checks++; if (bus.step_size !== rom(6'd6)) begin errors++; $display("FAIL b2b_step got %h want %h", bus.step_size, rom(6'd6)); end
    pulse_beat(); pulse_beat();
    checks++; if (bus.note_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", bus.note_done); end
    tick();
    checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.note_active); end
  endtask

  initial begin
    reset        = 1'b0;
    bus.play     = 1'b1;
    bus.new_note = 1'b0;
    bus.note     = '0;
    bus.duration = '0;
    bus.beat     = 1'b0;
    test_reset();
    test_ignore_paused();
    test_basic();
    test_rest_and_zero();
    test_pause();
    test_preempt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
